// File: rtl/dsm_pwm_out_pkg.sv
// Constants shared with the MASH delta-sigma modulator, plus the PWM output stage's
// selector for where the next frame's code comes from.
package dsm_pwm_out_pkg;

  localparam int DS_LEVELS = 10;
  localparam int DS_MID    = 5;
  localparam int DS_CODE_W = 4;

  typedef enum logic [1:0] {
    LOAD_MID    = 2'd0,
    LOAD_PEND   = 2'd1,
    LOAD_BYPASS = 2'd2
  } load_src_e;

endpackage

// File: rtl/dsm_pwm_out_window_calc.sv
// Combinational level code -> pulse window [lo, hi) in frame-counter units.
module pwm_window_calc
  import dsm_pwm_out_pkg::*;
#(
  parameter int SLOT   = 6,
  parameter int LEVELS = DS_LEVELS,
  parameter int CENTER = 1,
  parameter int W      = 7
) (
  input  logic [DS_CODE_W-1:0] code,
  output logic [W-1:0]         lo,
  output logic [W-1:0]         hi
);

  logic [W-1:0] width;
  logic [W-1:0] gap;

  // The code is already clamped to LEVELS, so the gap never goes negative.
  always_comb begin
    width = W'(code) * W'(SLOT);
    gap   = (W'(LEVELS) - W'(code)) * W'(SLOT);
    lo    = (CENTER != 0) ? (gap >> 1) : '0;
    hi    = lo + width;
  end

endmodule

// File: rtl/dsm_pwm_out.sv
// PWM output stage: one frame per modulator level code, with a one-deep pending
// buffer between the modulator strobe and the frame boundary, plus sticky rate flags.
module dsm_pwm_out
  import dsm_pwm_out_pkg::*;
#(
  parameter int SLOT   = 6,
  parameter int LEVELS = DS_LEVELS,
  parameter int CENTER = 1
) (
  input  logic                 ACLK,
  input  logic                 ARST,
  input  logic [DS_CODE_W-1:0] din,
  input  logic                 din_valid,
  output logic                 pwm_out,
  output logic                 frame_start,
  output logic                 underrun,
  output logic                 overrun,
  output logic                 sat,
  input  logic                 clr_status
);

  localparam int FRAME_LEN = LEVELS * SLOT;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int WIN_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [DS_CODE_W-1:0] CODE_MAX = DS_CODE_W'(LEVELS);
  localparam logic [DS_CODE_W-1:0] CODE_MID = DS_CODE_W'(DS_MID);

  logic [CNT_W-1:0]     cnt;
  logic [DS_CODE_W-1:0] active;
  logic [WIN_W-1:0]     lo;
  logic [WIN_W-1:0]     hi;
  logic [DS_CODE_W-1:0] pend;
  logic                 pend_valid;

  logic                 boundary;
  logic                 din_over;
  logic [DS_CODE_W-1:0] din_clamped;
  load_src_e            load_src;
  logic [DS_CODE_W-1:0] next_code;
  logic [DS_CODE_W-1:0] calc_code;
  logic [WIN_W-1:0]     lo_n;
  logic [WIN_W-1:0]     hi_n;
  logic                 set_underrun;
  logic                 set_overrun;
  logic                 set_sat;

  // An empty buffer at the boundary falls back to mid-scale silence rather than holding.
  always_comb begin
    boundary    = (cnt == CNT_LAST);
    din_over    = (din > CODE_MAX);
    din_clamped = din_over ? CODE_MAX : din;
    load_src    = LOAD_MID;
    next_code   = CODE_MID;
    if (pend_valid) begin
      load_src  = LOAD_PEND;
      next_code = pend;
    end else if (din_valid) begin
      load_src  = LOAD_BYPASS;
      next_code = din_clamped;
    end
    if (ARST)          calc_code = CODE_MID;
    else if (boundary) calc_code = next_code;
    else               calc_code = active;
    set_underrun = boundary && (load_src == LOAD_MID);
    set_overrun  = din_valid && pend_valid && !boundary;
    set_sat      = din_valid && din_over;
  end

  pwm_window_calc #(
    .SLOT  (SLOT),
    .LEVELS(LEVELS),
    .CENTER(CENTER),
    .W     (WIN_W)
  ) u_window (
    .code(calc_code),
    .lo  (lo_n),
    .hi  (hi_n)
  );

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      cnt         <= '0;
      active      <= CODE_MID;
      lo          <= lo_n;
      hi          <= hi_n;
      pend        <= '0;
      pend_valid  <= 1'b0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      sat         <= 1'b0;
    end else begin
      cnt <= boundary ? '0 : cnt + 1'b1;
      lo  <= lo_n;
      hi  <= hi_n;
      if (boundary) active <= next_code;

      // A bypassed code goes straight to active, so it must not also sit in pend.
      if (din_valid && !(boundary && (load_src == LOAD_BYPASS))) begin
        pend       <= din_clamped;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end

      pwm_out     <= ({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi);
      frame_start <= (cnt == '0);

      underrun <= set_underrun ? 1'b1 : (clr_status ? 1'b0 : underrun);
      overrun  <= set_overrun  ? 1'b1 : (clr_status ? 1'b0 : overrun);
      sat      <= set_sat      ? 1'b1 : (clr_status ? 1'b0 : sat);
    end
  end

endmodule

// File: tb/tb_dsm_pwm_out.sv
// Directed bench for dsm_pwm_out: a centre-aligned and a left-aligned instance share
// the same stimulus; each frame is captured bit by bit and compared to its window.
module tb_dsm_pwm_out;

  logic       ACLK = 1'b0;
  logic       ARST = 1'b1;
  logic [3:0] din = 4'd0;
  logic       din_valid = 1'b0;
  logic       clr_status = 1'b0;
  logic       pwm_out, frame_start, underrun, overrun, sat;
  logic       pwm_out_l, frame_start_l, underrun_l, overrun_l, sat_l;

  int checks = 0;
  int errors = 0;

  logic [59:0] win, win_l;
  logic        fs_l0;
  int          fs_extra;

  dsm_pwm_out dut (
    .ACLK(ACLK), .ARST(ARST), .din(din), .din_valid(din_valid),
    .pwm_out(pwm_out), .frame_start(frame_start), .underrun(underrun),
    .overrun(overrun), .sat(sat), .clr_status(clr_status)
  );

  dsm_pwm_out #(.CENTER(0)) dut_l (
    .ACLK(ACLK), .ARST(ARST), .din(din), .din_valid(din_valid),
    .pwm_out(pwm_out_l), .frame_start(frame_start_l), .underrun(underrun_l),
    .overrun(overrun_l), .sat(sat_l), .clr_status(clr_status)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] mk_win(input int lo, input int hi);
    logic [59:0] v;
    for (int i = 0; i < 60; i++) v[i] = (i >= lo) && (i < hi);
    return v;
  endfunction

  task automatic send(input logic [3:0] code);
    din       = code;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic clear_flags();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  // Leaves the bench where pwm_out shows cnt 0 (the counter itself is at 1).
  task automatic sync_frame();
    int n;
    tick();
    n = 1;
    while (frame_start !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    check("frame_sync", {63'd0, frame_start}, 64'd1);
  endtask

  // Ends where pwm_out shows cnt 59 and the counter has just wrapped to 0.
  task automatic measure(output logic [59:0] w, output logic [59:0] wl,
                         output logic fsl, output int extra);
    sync_frame();
    extra = 0;
    fsl   = frame_start_l;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) begin
        tick();
        if (frame_start) extra++;
      end
      w[i]  = pwm_out;
      wl[i] = pwm_out_l;
    end
  endtask

  initial begin
    // Reset, then two idle frames at mid-scale
    repeat (3) tick();
    check("reset_outputs", {59'd0, pwm_out, frame_start, underrun, overrun, sat}, 64'd0);
    ARST = 1'b0;
    measure(win, win_l, fs_l0, fs_extra);
    check("idle_frame1", win, mk_win(15, 45));
    check("idle_frame1_left", win_l, mk_win(0, 30));
    check("frame_start_once", fs_extra, 0);
    check("idle_underrun1", {63'd0, underrun}, 64'd1);
    measure(win, win_l, fs_l0, fs_extra);
    check("idle_frame2", win, mk_win(15, 45));
    check("idle_flags", {61'd0, underrun, overrun, sat}, 64'b100);
    clear_flags();
    check("underrun_cleared", {63'd0, underrun}, 64'd0);

    // Codes 0, 10 and 3, one per frame
    send(4'd0);
    measure(win, win_l, fs_l0, fs_extra);
    check("code0_all_low", win, 60'd0);
    send(4'd10);
    measure(win, win_l, fs_l0, fs_extra);
    check("code10_all_high", win, {60{1'b1}});
    send(4'd3);
    measure(win, win_l, fs_l0, fs_extra);
    check("code3_window", win, mk_win(21, 39));
    check("code3_window_left", win_l, mk_win(0, 18));
    check("code3_no_extra_fs", fs_extra, 0);

    // Saturation
    send(4'd13);
    check("sat_set", {63'd0, sat}, 64'd1);
    measure(win, win_l, fs_l0, fs_extra);
    check("code13_clamped", win, {60{1'b1}});
    clear_flags();
    check("sat_cleared", {63'd0, sat}, 64'd0);

    // Overrun: 4 then 7 in one frame, newer wins
    send(4'd4);
    repeat (3) tick();
    send(4'd7);
    check("overrun_set", {63'd0, overrun}, 64'd1);
    measure(win, win_l, fs_l0, fs_extra);
    check("code7_window", win, mk_win(9, 51));
    clear_flags();
    check("overrun_cleared", {63'd0, overrun}, 64'd0);
    send(4'd1);
    din = 4'd2; din_valid = 1'b1; clr_status = 1'b1;
    tick();
    din_valid = 1'b0; clr_status = 1'b0;
    check("overrun_set_beats_clr", {63'd0, overrun}, 64'd1);
    check("underrun_clr_with_set", {63'd0, underrun}, 64'd0);
    measure(win, win_l, fs_l0, fs_extra);
    check("code2_after_overwrite", win, mk_win(24, 36));

    // Bypass: pend empty, strobe on the boundary cycle (cnt 59)
    clear_flags();
    repeat (58) tick();
    send(4'd2);
    check("bypass_no_flags", {62'd0, underrun, overrun}, 64'd0);
    measure(win, win_l, fs_l0, fs_extra);
    check("bypass_code2", win, mk_win(24, 36));

    // Pend full on the boundary: 8 consumed, 4 stored
    clear_flags();
    send(4'd8);
    repeat (57) tick();
    send(4'd4);
    check("refill_no_flags", {62'd0, underrun, overrun}, 64'd0);
    measure(win, win_l, fs_l0, fs_extra);
    check("refill_code8", win, mk_win(6, 54));
    check("refill_no_underrun", {63'd0, underrun}, 64'd0);
    measure(win, win_l, fs_l0, fs_extra);
    check("refill_code4", win, mk_win(18, 42));

    // Reset at cnt 30 of a full-scale frame
    send(4'd10);
    sync_frame();
    repeat (29) tick();
    check("pre_reset_high", {63'd0, pwm_out}, 64'd1);
    ARST = 1'b1;
    tick();
    check("midframe_reset", {59'd0, pwm_out, frame_start, underrun, overrun, sat}, 64'd0);
    ARST = 1'b0;
    measure(win, win_l, fs_l0, fs_extra);
    check("post_reset_mid", win, mk_win(15, 45));
    check("post_reset_underrun", {63'd0, underrun}, 64'd1);

    // Left-aligned build alongside the centred one
    send(4'd5);
    measure(win, win_l, fs_l0, fs_extra);
    check("code5_centre", win, mk_win(15, 45));
    check("code5_left", win_l, mk_win(0, 30));
    check("left_fs_with_first_bit", {62'd0, fs_l0, win_l[0]}, 64'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
